// File: rtl/pipe_add_sub.sv
// Pipelined adder/subtractor: one carry-chained segment summed per stage, valid/ready on both sides.
// Define PIPE_ADD_SUB_FLAGS_EN to compute and register the V and Z flags.
module pipe_add_sub #(
  parameter int unsigned AdderWidth = 16,
  parameter int unsigned StageWidth = 8
) (
  input  logic                  cp2,
  input  logic                  ireset,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic                  sub,
  input  logic [AdderWidth-1:0] A,
  input  logic [AdderWidth-1:0] B,
  input  logic                  CI,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [AdderWidth-1:0] S,
  output logic                  CO,
  output logic                  V,
  output logic                  Z
);

  localparam int unsigned NStages = AdderWidth / StageWidth;
  localparam int unsigned Last    = NStages - 1;

  logic                  adv;
  logic [NStages-1:0]    vldQ, subQ, carryQ;
  logic [NStages-1:0]    vldIn, subIn, cIn, carryD;
  logic [AdderWidth-1:0] opAQ [NStages];
  logic [AdderWidth-1:0] opBQ [NStages];
  logic [AdderWidth-1:0] sumQ [NStages];
  logic [AdderWidth-1:0] aIn  [NStages];
  logic [AdderWidth-1:0] bIn  [NStages];
  logic [AdderWidth-1:0] sIn  [NStages];
  logic [AdderWidth-1:0] sumD [NStages];
  logic [StageWidth:0]   segSum [NStages];

  // The whole pipe moves or holds as one; stage 0 loads in_vld whenever it moves.
  assign adv     = !vldQ[Last] || out_rdy;
  assign in_rdy  = adv;
  assign out_vld = vldQ[Last];
  assign S       = sumQ[Last];
  assign CO      = subQ[Last] ^ carryQ[Last];

  always_comb begin
    vldIn[0] = in_vld;
    subIn[0] = sub;
    aIn[0]   = A;
    bIn[0]   = sub ? ~B : B;
    cIn[0]   = sub ? !CI : CI;
    sIn[0]   = '0;
    for (int k = 1; k < NStages; k++) begin
      vldIn[k] = vldQ[k-1];
      subIn[k] = subQ[k-1];
      aIn[k]   = opAQ[k-1];
      bIn[k]   = opBQ[k-1];
      cIn[k]   = carryQ[k-1];
      sIn[k]   = sumQ[k-1];
    end
    // Stage k fills segment k; lower segments ride along already summed, upper ones not yet.
    for (int k = 0; k < NStages; k++) begin
      segSum[k] = {1'b0, aIn[k][k*StageWidth +: StageWidth]}
                + {1'b0, bIn[k][k*StageWidth +: StageWidth]}
                + {{StageWidth{1'b0}}, cIn[k]};
      sumD[k] = sIn[k];
      sumD[k][k*StageWidth +: StageWidth] = segSum[k][StageWidth-1:0];
      carryD[k] = segSum[k][StageWidth];
    end
  end

  always_ff @(posedge cp2) begin
    if (ireset) begin
      vldQ   <= '0;
      subQ   <= '0;
      carryQ <= '0;
      for (int k = 0; k < NStages; k++) begin
        opAQ[k] <= '0;
        opBQ[k] <= '0;
        sumQ[k] <= '0;
      end
    end else if (adv) begin
      vldQ   <= vldIn;
      subQ   <= subIn;
      carryQ <= carryD;
      for (int k = 0; k < NStages; k++) begin
        opAQ[k] <= aIn[k];
        opBQ[k] <= bIn[k];
        sumQ[k] <= sumD[k];
      end
    end
  end

`ifdef PIPE_ADD_SUB_FLAGS_EN
  logic vD, zD, vQ, zQ;

  // Flags are resolved alongside the final segment so they register with S.
  assign vD = (aIn[Last][AdderWidth-1] == bIn[Last][AdderWidth-1])
           && (sumD[Last][AdderWidth-1] != aIn[Last][AdderWidth-1]);
  assign zD = (sumD[Last] == '0);

  always_ff @(posedge cp2) begin
    if (ireset) begin
      vQ <= 1'b0;
      zQ <= 1'b0;
    end else if (adv) begin
      vQ <= vD;
      zQ <= zD;
    end
  end

  assign V = vQ;
  assign Z = zQ;
`else
  assign V = 1'b0;
  assign Z = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_add_sub.sv
// Bench for pipe_add_sub (16-bit, 8-bit stages): directed table, backpressure, reset flush and a
// random stream, all checked through an in-order scoreboard of expected results.
module tb_pipe_add_sub;

  logic        cp2 = 1'b0;
  logic        ireset, in_vld, in_rdy, sub, CI, out_vld, out_rdy, CO, V, Z;
  logic [15:0] A, B, S;

  pipe_add_sub #(
    .AdderWidth(16),
    .StageWidth(8)
  ) dut (
    .cp2    (cp2),
    .ireset (ireset),
    .in_vld (in_vld),
    .in_rdy (in_rdy),
    .sub    (sub),
    .A      (A),
    .B      (B),
    .CI     (CI),
    .out_vld(out_vld),
    .out_rdy(out_rdy),
    .S      (S),
    .CO     (CO),
    .V      (V),
    .Z      (Z)
  );

  always #5 cp2 = ~cp2;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        v;
    logic        z;
  } res_t;

  typedef struct {
    logic        sb;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        co;
    logic        v;
    logic        z;
  } vec_t;

  res_t expQ[$];
  int   nVec = 0;
  int   nErr = 0;
  bit   sendDone;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nVec++;
    if (act !== req) begin
      nErr++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Without the flag build V and Z are tied low.
  function automatic res_t maskFlags(input res_t r);
    res_t m;
    m = r;
`ifndef PIPE_ADD_SUB_FLAGS_EN
    m.v = 1'b0;
    m.z = 1'b0;
`endif
    return m;
  endfunction

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic res_t model(input logic sb, input logic [15:0] a, input logic [15:0] b,
                                 input logic ci);
    res_t        r;
    logic [16:0] u;
    int          sv;
    if (!sb) begin
      u  = {1'b0, a} + {1'b0, b} + {16'b0, ci};
      sv = int'($signed(a)) + int'($signed(b)) + int'(ci);
    end else begin
      u  = {1'b0, a} - {1'b0, b} - {16'b0, ci};
      sv = int'($signed(a)) - int'($signed(b)) - int'(ci);
    end
    r.s  = u[15:0];
    r.co = u[16];
    r.v  = (sv > 32767) || (sv < -32768);
    r.z  = (u[15:0] == 16'h0000);
    return maskFlags(r);
  endfunction

  // Holds in_vld until accepted; expected result is queued at the accepting edge.
  task automatic send(input logic sb, input logic [15:0] a, input logic [15:0] b, input logic ci,
                      input res_t e);
    int n;
    sub    = sb;
    A      = a;
    B      = b;
    CI     = ci;
    in_vld = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(negedge cp2);
      if (in_rdy) break;
    end
    if (n == 100) begin
      nVec++;
      nErr++;
      $display("FAIL accept_timeout: in_rdy stayed 0 for 100 cycles, required 1");
      in_vld = 1'b0;
      return;
    end
    expQ.push_back(e);
    @(posedge cp2);
    #1;
    in_vld = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && expQ.size() > 0; i++) @(posedge cp2);
    #1;
    chk("drain_pending", expQ.size(), 0);
  endtask

  // Output monitor: pops on every transfer, checks hold stability while stalled.
  res_t expR, got, heldOut;
  logic stallPrev = 1'b0;

  always @(negedge cp2) begin
    if (ireset) begin
      expQ.delete();
      stallPrev = 1'b0;
    end else begin
      got = {S, CO, V, Z};
      if (stallPrev && out_vld) chk("stall_hold", got, heldOut);
      if (out_vld && out_rdy) begin
        if (expQ.size() == 0) begin
          nVec++;
          nErr++;
          $display("FAIL extra_output: got S=%0h with nothing pending, required no output", S);
        end else begin
          expR = expQ.pop_front();
          chk("S", S, expR.s);
          chk("CO", CO, expR.co);
          chk("V", V, expR.v);
          chk("Z", Z, expR.z);
        end
      end
      stallPrev = out_vld && !out_rdy;
      heldOut   = got;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ireset  = 1'b1;
    in_vld  = 1'b0;
    sub     = 1'b0;
    A       = '0;
    B       = '0;
    CI      = 1'b0;
    out_rdy = 1'b1;

    tbl[0]  = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 16'h0100, 16'h0001, 1'b1, 16'h00FE, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 16'h00FF, 16'hFF00, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge cp2);
    @(negedge cp2);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_S", S, 0);
    chk("rst_CO", CO, 0);
    chk("rst_V", V, 0);
    chk("rst_Z", Z, 0);
    @(posedge cp2);
    #1;
    ireset = 1'b0;

    // Directed table, back to back
    foreach (tbl[i])
      send(tbl[i].sb, tbl[i].a, tbl[i].b, tbl[i].ci,
           maskFlags({tbl[i].s, tbl[i].co, tbl[i].v, tbl[i].z}));
    drain();

    // Backpressure: two accepted, then in_rdy must drop until out_rdy returns
    out_rdy = 1'b0;
    send(1'b0, 16'd1, 16'd1, 1'b0, model(1'b0, 16'd1, 16'd1, 1'b0));
    send(1'b0, 16'd2, 16'd2, 1'b0, model(1'b0, 16'd2, 16'd2, 1'b0));
    @(negedge cp2);
    chk("bp_in_rdy_low", in_rdy, 0);
    chk("bp_out_vld", out_vld, 1);
    chk("bp_head_S", S, 16'd2);
    fork
      begin
        send(1'b0, 16'd3, 16'd3, 1'b0, model(1'b0, 16'd3, 16'd3, 1'b0));
        send(1'b0, 16'd4, 16'd4, 1'b0, model(1'b0, 16'd4, 16'd4, 1'b0));
      end
      begin
        repeat (2) begin
          @(negedge cp2);
          chk("bp_hold_in_rdy", in_rdy, 0);
        end
        @(posedge cp2);
        #1;
        out_rdy = 1'b1;
        repeat (4) begin
          @(negedge cp2);
          chk("bp_no_gap", out_vld, 1);
        end
      end
    join
    drain();

    // Reset mid-operation: queued ops must vanish
    @(posedge cp2);
    #1;
    out_rdy = 1'b0;
    send(1'b0, 16'h0011, 16'h0022, 1'b0, model(1'b0, 16'h0011, 16'h0022, 1'b0));
    send(1'b1, 16'h0100, 16'h0001, 1'b0, model(1'b1, 16'h0100, 16'h0001, 1'b0));
    ireset = 1'b1;
    @(posedge cp2);
    #1;
    ireset = 1'b0;
    @(negedge cp2);
    chk("flush_out_vld", out_vld, 0);
    chk("flush_in_rdy", in_rdy, 1);
    out_rdy = 1'b1;
    repeat (6) @(negedge cp2);
    @(posedge cp2);
    #1;
    // First op after reset: latency two
    send(1'b0, 16'h0005, 16'h0006, 1'b0, model(1'b0, 16'h0005, 16'h0006, 1'b0));
    @(negedge cp2);
    chk("lat_cycle1_out_vld", out_vld, 0);
    @(negedge cp2);
    chk("lat_cycle2_out_vld", out_vld, 1);
    drain();

    // Random stream with random gaps and backpressure
    sendDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          logic        rs, rc;
          logic [15:0] ra, rb;
          rs = 1'($urandom_range(0, 1));
          rc = 1'($urandom_range(0, 1));
          ra = 16'($urandom);
          rb = 16'($urandom);
          if (i % 10 == 0) ra = 16'h8000;
          if (i % 10 == 1) rb = ra;
          while ($urandom_range(0, 3) == 0) begin
            @(posedge cp2);
            #1;
          end
          send(rs, ra, rb, rc, model(rs, ra, rb, rc));
        end
        sendDone = 1'b1;
      end
      begin
        while (!sendDone) begin
          out_rdy = 1'($urandom_range(0, 1));
          @(posedge cp2);
          #1;
        end
      end
    join
    out_rdy = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/pipe_add_sub.md
# pipe_add_sub

Pipelined, parametrised adder/subtractor for the core datapath, the registered successor to the single-cycle combinational adder. Operands are split into carry-chained segments, one segment per pipeline stage, so wide additions close timing at `cp2` frequency. A valid/ready handshake on both sides lets the block sit between datapath registers or feed multi-cycle units (MUL/accumulator paths) with backpressure.

## Interface
- `AdderWidth`, default 16: operand and result width in bits.
- `StageWidth`, default 8: bits summed per stage. It must divide `AdderWidth`. `NStages = AdderWidth/StageWidth`.
- `cp2`  in  1: clock, rising-edge.
- `ireset`  in  1: reset, synchronous and active-high (already decided).
- `in_vld`  in  1: input operands valid.
- `in_rdy`  out  1: block accepts input this cycle.
- `sub`  in  1: 0 selects A+B+CI; 1 selects A−B−CI.
- `A`  in  AdderWidth: operand A.
- `B`  in  AdderWidth: operand B.
- `CI`  in  1: carry-in (add) or borrow-in (sub).
- `out_vld`  out  1: result valid.
- `out_rdy`  in  1: downstream accepts the result.
- `S`  out  AdderWidth: result.
- `CO`  out  1: carry-out (add) or borrow-out (sub).
- `V`  out  1: two's-complement overflow.
- `Z`  out  1: `S` is all zeros.

## Operation
- Transfer in when `in_vld && in_rdy`. Transfer out when `out_vld && out_rdy`.
- Global advance: `adv = !out_vld || out_rdy`. `in_rdy = adv` (combinational; no dependency on `in_vld`).
- When `adv` is 0, every stage register holds, including valid bits. When `adv` is 1, every stage shifts one step and stage 0 loads `in_vld`.
- Sub mode uses `B' = ~B` and `c0 = !CI`. Add mode uses `B' = B` and `c0 = CI`.
- Stage k (0…NStages−1) sums segment k of A and B' plus the carry registered by stage k−1. Stage 0 uses `c0`.
- Upper, not-yet-summed segments are skewed forward through delay registers. Lower, completed sum segments are delayed so all segments align at the output.
- Final carry c. `CO = c` in add mode; `CO = !c` in sub mode (1 = borrow).
- `V = (A[msb] == B'[msb]) && (S[msb] != A[msb])`, evaluated using the original operand MSBs carried down the pipe.
- `Z = (S == 0)`.
- Results exit in order. No reordering, no drops, no duplicates.
- Arithmetic is modulo 2^AdderWidth. `CO` carries the bit beyond the MSB.

## Timing
- Latency: `NStages` cycles from an accepted input to `out_vld`, with no stall. With `NStages = 1`, that is one registered cycle.
- Throughput: one operation per cycle while `out_rdy` stays high.
- Reset: on `cp2` with `ireset = 1`, all stage valid bits clear. `out_vld` reads 0 in the following cycle.
- Reset values: `S = 0`, `CO = 0`, `V = 0`, `Z = 0`, `out_vld = 0`. `in_rdy = 1` after reset (follows `adv`).
- Reset mid-operation: in-flight operations are discarded and never presented.
- Reset has priority over simultaneous transfers.
- Stall with a full pipe: up to `NStages` operations are held. `in_rdy = 0` until `out_rdy` rises.
- Simultaneous in/out transfer when full is legal. It gives no bubble and no loss.
- `S`, `CO`, `V` and `Z` are stable while `out_vld && !out_rdy`.
- Bubble stages (valid = 0) may carry arbitrary data. Outputs other than `out_vld` are don't-care while `out_vld = 0`.

## Configuration
- `PIPE_ADD_SUB_FLAGS_EN` defined: `V` and `Z` are computed and registered as specified.
- Undefined: the MSB/flag delay registers are omitted. `V` and `Z` are tied to 0. Ports remain, and `S`/`CO` behaviour is unchanged.

## Test plan
Bench uses AdderWidth=16, StageWidth=8 (latency 2), flags enabled.

- Add 0xFFFF + 0x0001, CI=0 -> two cycles later `S=0x0000`, `CO=1`, `Z=1`, `V=0`.
- Add 0x7FFF + 0x0000, CI=1 -> `S=0x8000`, `CO=0`, `V=1`, `Z=0`. This exercises the cross-segment carry.
- Sub 0x0000 − 0x0001, CI=0 -> `S=0xFFFF`, `CO=1`, `V=0`. Then sub 0x8000 − 0x0001, CI=0 -> `S=0x7FFF`, `CO=0`, `V=1`.
- Backpressure: issue 4 back-to-back adds (1+1, 2+2, 3+3, 4+4) with `out_rdy=0` -> `in_rdy` drops after 2 accepted. Release `out_rdy` -> results 2, 4, 6, 8 emerge in order with no gaps or duplicates.
- Reset mid-operation: accept two ops, assert `ireset` one cycle -> `out_vld=0` next cycle, neither result ever appears. The next op after reset returns with latency 2.
- Streaming: 100 random add/sub ops with random `in_vld`/`out_rdy` -> the output sequence matches the reference model bit-exactly for `S`, `CO`, `V` and `Z`.
